// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Collects rising edges on the request lines from the interrupt splitter,
//   latches them as pending, and presents the highest-priority unmasked
//   pending line to the CPU as a single irq with its code. The CPU retires
//   the presented interrupt with a one-cycle irq_ack pulse.
//
//   Line 1 has the highest priority. Code 0 means "no interrupt", so the
//   controller serves 2^CODE_WIDTH-1 lines numbered 1..NUM_LINES.
//
// Ports:
//   clk            system clock; all state changes on its rising edge
//   rst            synchronous, active-high reset
//   requests       request lines [NUM_LINES:1], level or pulse, synchronous
//   global_enable  0 blocks new irq assertion; pending bits still latch
//   mask_wr        one-cycle strobe loading mask_data into the mask register
//   mask_data      new mask value; 1 = line enabled
//   irq            interrupt request to the CPU
//   irq_code       code of the presented interrupt; 0 when irq=0
//   irq_ack        one-cycle CPU acknowledge of the presented interrupt
//   pending        current pending register (status)
//   mask           current mask register (status)
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int  CODE_WIDTH = 4,
    localparam int NUM_LINES  = (1 << CODE_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LINES:1]    requests,
    input  logic                  global_enable,
    input  logic                  mask_wr,
    input  logic [NUM_LINES:1]    mask_data,
    output logic                  irq,
    output logic [CODE_WIDTH-1:0] irq_code,
    input  logic                  irq_ack,
    output logic [NUM_LINES:1]    pending,
    output logic [NUM_LINES:1]    mask
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state_q,   state_d;
    logic [CODE_WIDTH-1:0] code_q,    code_d;
    logic [NUM_LINES:1]    pending_q, pending_d;
    logic [NUM_LINES:1]    mask_q,    mask_d;
    logic [NUM_LINES:1]    prev_q,    prev_d;

    logic [NUM_LINES:1]    rise;
    logic [NUM_LINES:1]    elig;
    logic [NUM_LINES:1]    ack_clr;
    logic                  win_valid;
    logic [CODE_WIDTH-1:0] win_code;

    // -------------------------------------------------------------------------
    // Edge detection and eligibility
    // -------------------------------------------------------------------------
    // prev resets to 0, so a line held high through reset yields one edge.
    assign rise = requests & ~prev_q;

    // The IDLE decision looks at the registered mask, so a mask_wr in the
    // same cycle only takes effect from the following decision.
    assign elig = pending_q & mask_q;

    // Fixed priority: scanning from the top down lets the lowest index
    // overwrite any higher one, so line 1 always wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        win_valid = 1'b0;
        win_code  = '0;
        for (int i = NUM_LINES; i >= 1; i--) begin
            if (elig[i]) begin
                win_valid = 1'b1;
                win_code  = CODE_WIDTH'(i);
            end
        end
    end

    // One-hot decode of the presented code, used to retire its pending bit.
    always_comb begin
        ack_clr = '0;
        for (int i = 1; i <= NUM_LINES; i++) begin
            ack_clr[i] = (code_q == CODE_WIDTH'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pending_d = pending_q;
        mask_d    = mask_wr ? mask_data : mask_q;
        prev_d    = requests;

        unique case (state_q)
            IDLE: begin
                // irq_ack is ignored here: nothing is presented to retire.
                if (global_enable && win_valid) begin
                    state_d = ACTIVE;
                    code_d  = win_code;
                end
            end
            ACTIVE: begin
                // The presented code is frozen until acknowledged; mask,
                // enable and new arrivals cannot withdraw it.
                if (irq_ack) begin
                    state_d   = IDLE;
                    code_d    = '0;
                    pending_d = pending_q & ~ack_clr;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase

        // New edges are merged after the ack clear, so an edge arriving on the
        // line being retired survives as a fresh pending event.
        pending_d = pending_d | rise;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= prev_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign irq      = (state_q == ACTIVE);
    assign irq_code = code_q;
    assign pending  = pending_q;
    assign mask     = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the controller runs alongside the DUT and its outputs are compared on every
// falling edge; directed scenarios add literal expectations sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    localparam int CW = 4;
    localparam int N  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N:1]    requests = '0;
    logic          global_enable = 1'b0;
    logic          mask_wr = 1'b0;
    logic [N:1]    mask_data = '0;
    logic          irq;
    logic [CW-1:0] irq_code;
    logic          irq_ack = 1'b0;
    logic [N:1]    pending;
    logic [N:1]    mask;

    int n_checks = 0;
    int n_pass   = 0;
    bit compare_on = 1'b0;

    interrupt_controller #(.CODE_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .requests     (requests),
        .global_enable(global_enable),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .irq          (irq),
        .irq_code     (irq_code),
        .irq_ack      (irq_ack),
        .pending      (pending),
        .mask         (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, actual, expected, $time);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: pending/mask as bit arrays, a busy flag and a code.
    // -------------------------------------------------------------------------
    bit m_pending [1:N];
    bit m_mask    [1:N];
    bit m_prev    [1:N];
    bit m_busy;
    int m_code;

    function automatic logic [N:1] pack(input bit a [1:N]);
        logic [N:1] v;
        v = '0;
        for (int i = 1; i <= N; i++) if (a[i]) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= N; i++) begin
                m_pending[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
            end
            m_busy = 0;
            m_code = 0;
        end else begin
            bit new_edge [1:N];
            for (int i = 1; i <= N; i++) new_edge[i] = requests[i] && !m_prev[i];
            if (m_busy) begin
                if (irq_ack) begin
                    m_pending[m_code] = 0;
                    m_busy = 0;
                    m_code = 0;
                end
            end else if (global_enable) begin
                for (int i = 1; i <= N; i++) begin
                    if (m_pending[i] && m_mask[i]) begin
                        m_busy = 1;
                        m_code = i;
                        break;
                    end
                end
            end
            for (int i = 1; i <= N; i++) begin
                if (new_edge[i]) m_pending[i] = 1;
                m_prev[i] = requests[i];
                if (mask_wr) m_mask[i] = mask_data[i];
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check("model_irq",      32'(irq),      32'(m_busy));
            check("model_irq_code", 32'(irq_code), 32'(m_code));
            check("model_pending",  32'(pending),  32'(pack(m_pending)));
            check("model_mask",     32'(mask),     32'(pack(m_mask)));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N:1] line(input int i);
        logic [N:1] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic wait_irq(input int max_cycles);
        int n;
        n = 0;
        while (!irq && n < max_cycles) begin
            step();
            n++;
        end
        check("wait_irq_timeout", 32'(irq), 32'd1);
    endtask

    task automatic write_mask(input logic [N:1] v);
        mask_wr = 1'b1;
        mask_data = v;
        step();
        mask_wr = 1'b0;
    endtask

    initial begin
        int serviced;

        // Reset state
        rst = 1'b1;
        step();
        step();
        compare_on = 1'b1;
        check("reset_irq",      32'(irq),      32'd0);
        check("reset_irq_code", 32'(irq_code), 32'd0);
        check("reset_pending",  32'(pending),  32'd0);
        check("reset_mask",     32'(mask),     32'd0);
        rst = 1'b0;
        global_enable = 1'b1;
        write_mask(15'h7FFF);

        // Single pulse on line 3: pending next cycle, irq one cycle later
        requests = line(3);
        step();
        requests = '0;
        check("t1_pending3", 32'(pending), 32'h0004);
        check("t1_irq_early", 32'(irq), 32'd0);
        step();
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_code", 32'(irq_code), 32'd3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t1_ack_irq", 32'(irq), 32'd0);
        check("t1_ack_code", 32'(irq_code), 32'd0);
        check("t1_ack_pending", 32'(pending), 32'd0);

        // Lines 5 and 2 together: 2 first, one idle cycle, then 5
        requests = line(5) | line(2);
        step();
        requests = '0;
        step();
        check("t2_code_first", 32'(irq_code), 32'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_gap_irq", 32'(irq), 32'd0);
        step();
        check("t2_code_second", 32'(irq_code), 32'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_pending_empty", 32'(pending), 32'd0);

        // Masked line stays pending; unmasking presents it two cycles later
        write_mask('0);
        requests = line(4);
        step();
        requests = '0;
        step();
        check("t3_pending4", 32'(pending), 32'h0008);
        check("t3_irq_masked", 32'(irq), 32'd0);
        write_mask(line(4));
        check("t3_irq_one_after", 32'(irq), 32'd0);
        step();
        check("t3_irq", 32'(irq), 32'd1);
        check("t3_code", 32'(irq_code), 32'd4);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        write_mask(15'h7FFF);
        step();

        // Line 6 held high for 20 cycles: only one interrupt
        serviced = 0;
        requests = line(6);
        for (int c = 0; c < 20; c++) begin
            irq_ack = irq;
            if (irq) serviced++;
            step();
        end
        irq_ack = 1'b0;
        requests = '0;
        step();
        step();
        check("t4_serviced_once", 32'(serviced), 32'd1);
        check("t4_pending_empty", 32'(pending), 32'd0);

        // New edge on line 6 in the same cycle as its ack: stays pending
        requests = line(6);
        step();
        requests = '0;
        wait_irq(5);
        check("t4_code6", 32'(irq_code), 32'd6);
        requests = line(6);
        irq_ack = 1'b1;
        step();
        requests = '0;
        irq_ack = 1'b0;
        check("t4_set_wins", 32'(pending), 32'h0020);
        check("t4_idle_gap", 32'(irq), 32'd0);
        step();
        check("t4_represent", 32'(irq_code), 32'd6);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();

        // Active with code 7: higher-priority arrival and unmasking ignored
        requests = line(7);
        step();
        requests = '0;
        wait_irq(5);
        requests = line(1);
        mask_wr = 1'b1;
        mask_data = 15'h7FFF & ~line(7);
        step();
        requests = '0;
        mask_wr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t5_code_frozen", 32'(irq_code), 32'd7);
            step();
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t5_gap", 32'(irq), 32'd0);
        step();
        check("t5_code1", 32'(irq_code), 32'd1);

        // Reset while irq is asserted; a later ack changes nothing
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_irq", 32'(irq), 32'd0);
        check("t6_code", 32'(irq_code), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        check("t6_mask", 32'(mask), 32'd0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t6_ack_ignored_irq", 32'(irq), 32'd0);
        check("t6_ack_ignored_pending", 32'(pending), 32'd0);

        // Randomized traffic against the model
        write_mask(15'h7FFF);
        for (int c = 0; c < 3000; c++) begin
            requests      = N'($urandom & $urandom & $urandom);
            global_enable = ($urandom_range(0, 9) != 0);
            irq_ack       = irq ? ($urandom_range(0, 2) == 0)
                                : ($urandom_range(0, 9) == 0);
            mask_wr       = ($urandom_range(0, 19) == 0);
            mask_data     = N'($urandom | $urandom);
            rst           = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        irq_ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Sits directly downstream of the interrupt splitter and consumes its 15-line request vector. It detects rising edges on each line, latches them as pending, and applies a per-line mask and a global enable. It selects the highest-priority unmasked pending line and presents it to the CPU as a single irq with its code. The CPU acknowledges with a one-cycle handshake.

Parameters:
CODE_WIDTH, 4, width of the interrupt code. The number of request lines is 2^CODE_WIDTH-1. Code 0 means "no interrupt".

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
requests  input  [15:1]  request lines from the splitter, level or pulse, already synchronous to clk
global_enable  input  1  0 blocks new irq assertion; pending bits still latch
mask_wr  input  1  one-cycle strobe that loads mask_data into the mask register
mask_data  input  [15:1]  new mask value; 1 = line enabled
irq  output  1  interrupt request to the CPU
irq_code  output  [3:0]  code of the presented interrupt; 0 when irq=0
irq_ack  input  1  one-cycle CPU acknowledge of the presented interrupt
pending  output  [15:1]  current pending register, for status reads
mask  output  [15:1]  current mask register

Behaviour:
- Reset values:
  - irq=0, irq_code=0, pending=0, mask=0 (all lines disabled).
  - Previous-sample register prev=0, state=IDLE.
  - Because prev resets to 0, a line held high through reset registers exactly one edge after reset.
- Edge detect:
  - prev <= requests every cycle.
  - rise = requests & ~prev.
  - pending[i] <= 1 on rise[i]. A line held high produces only one edge.
- Mask:
  - On mask_wr, mask <= mask_data at that edge.
  - Masking does not clear pending; a masked pending bit is kept and serviced once unmasked.
- Eligible vector: elig = pending & mask, considered only when global_enable=1.
- Priority: the lowest index wins (line 1 is the highest priority). Fixed priority, no rotation.
- FSM, two states:
  - IDLE:
    - irq=0, irq_code=0.
    - If global_enable and elig!=0, go to ACTIVE next edge, registering irq_code=the winning index and irq=1.
  - ACTIVE:
    - irq=1 and irq_code are held frozen.
    - Changes to mask, global_enable or higher-priority arrivals do not alter or withdraw the request.
    - On irq_ack: clear pending[irq_code], go to IDLE, and drive irq=0, irq_code=0 from the next cycle.
    - The mandatory single IDLE cycle gives the CPU a visible deassertion between interrupts.
- Latency:
  - A request edge sampled at clock edge k sets pending after edge k.
  - irq is asserted after edge k+1 (2 cycles from request to irq) when the controller is idle and the line is eligible.
- Simultaneous events:
  - A rise on the same line being cleared by irq_ack in the same cycle leaves pending=1 (set wins), so the new event is not lost.
  - mask_wr in the same cycle as the IDLE decision: the decision uses the old mask.
- irq_ack while in IDLE is ignored, with no state or pending change.
- rst in any state, including ACTIVE mid-handshake, returns everything to the reset values on the next edge. Pending events are discarded.
- Code width: irq_code is zero-extended when CODE_WIDTH covers all 15 lines. No arithmetic is involved; the code equals the line index.

Test Plan:
- Post-reset, mask=0x7FFF, global_enable=1, pulse requests[3] for 1 cycle -> pending[3]=1 next cycle; irq=1 and irq_code=3 two cycles after the pulse; irq_ack -> pending[3]=0, irq=0 and irq_code=0 the next cycle.
- Raise requests[5] and requests[2] in the same cycle -> code 2 presented first; after ack, one cycle with irq=0; then code 5 presented; after ack, pending=0.
- mask=0 with requests[4] pulsed -> pending[4]=1 and irq stays 0; write mask bit 4 -> irq=1, irq_code=4 two cycles after mask_wr.
- Hold requests[6] high for 20 cycles with repeated acks -> exactly one interrupt serviced. Pulse requests[6] again in the same cycle as its irq_ack -> pending[6] stays 1 and code 6 is re-presented after the IDLE cycle.
- In ACTIVE with code 7, pulse requests[1] and clear mask bit 7 -> irq_code stays 7 until ack; then code 1 is presented.
- Assert rst while irq=1 -> irq=0, irq_code=0, pending=0, mask=0 after that edge. An irq_ack afterwards has no effect.
